// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
//   Shared definitions for the FIR filter family (decimating fir and fir_interp).
//   - QUANT_BITS : fractional bits of the Q10 coefficient format
//   - ACC_GUARD  : extra accumulator headroom bits, 8 when FIR_INTERP_SAT_EN is
//                  defined (saturating build), 0 otherwise (wrapping build)
//   - fir_interp_state_t : READ / MAC / WRITE sequencer states
//   - dequantize : drops QUANT_BITS fractional bits, rounding toward zero
// -----------------------------------------------------------------------------
package fir_pkg;

  localparam int QUANT_BITS = 10;

  // Working width of dequantize; wide enough for any 2*DATA_SIZE product we use.
  localparam int DEQ_W = 128;

`ifdef FIR_INTERP_SAT_EN
  localparam int ACC_GUARD = 8;
`else
  localparam int ACC_GUARD = 0;
`endif

  typedef enum logic [1:0] {
    READ  = 2'd0,
    MAC   = 2'd1,
    WRITE = 2'd2
  } fir_interp_state_t;

  // Plain >>> would round negative products toward -inf; shifting the
  // magnitude instead makes e.g. -1 * 1 come out as 0, not -1.
  function automatic logic signed [DEQ_W-1:0] dequantize(
    input logic signed [DEQ_W-1:0] p
  );
    logic signed [DEQ_W-1:0] mag;
    logic signed [DEQ_W-1:0] result;
    if (p[DEQ_W-1]) begin
      mag    = -p;
      result = -(mag >>> QUANT_BITS);
    end else begin
      result = p >>> QUANT_BITS;
    end
    return result;
  endfunction

endpackage

// File: rtl/fir_interp_mac.sv
// -----------------------------------------------------------------------------
// fir_interp_mac
//   Combinational multiply-accumulate step of the serial polyphase FIR:
//     sum = acc + dequantize(sample * coeff)
//   The product is kept at full 2*DATA_SIZE precision before dequantizing.
//   Accumulator width comes from ACC_GUARD, i.e. from FIR_INTERP_SAT_EN.
// Ports
//   sample  in   DATA_SIZE  delay-line tap value
//   coeff   in   DATA_SIZE  prototype coefficient (Q10)
//   acc     in   ACC_W      running accumulator
//   sum     out  ACC_W      updated accumulator (wraps mod 2^ACC_W)
// -----------------------------------------------------------------------------
module fir_interp_mac
  import fir_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int ACC_W     = DATA_SIZE + ACC_GUARD
) (
  input  logic signed [DATA_SIZE-1:0] sample,
  input  logic signed [DATA_SIZE-1:0] coeff,
  input  logic signed [ACC_W-1:0]     acc,
  output logic signed [ACC_W-1:0]     sum
);

  logic signed [2*DATA_SIZE-1:0] product;
  logic signed [DEQ_W-1:0]       term;

  // NOTE: every variable gets a value on every pass through always_comb;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    product = (2*DATA_SIZE)'(sample) * (2*DATA_SIZE)'(coeff);
    term    = dequantize(DEQ_W'(product));
    sum     = acc + ACC_W'(term);
  end

endmodule

// File: rtl/fir_interp.sv
// -----------------------------------------------------------------------------
// fir_interp
//   Polyphase interpolating FIR. Pops one sample from the input FIFO, then for
//   each phase 0..INTERP-1 runs PHASE_TAPS serial MAC cycles and pushes one
//   output sample: INTERP outputs per input, INTERP*(PHASE_TAPS+1)+1 cycles per
//   input without backpressure.
//   Build option FIR_INTERP_SAT_EN: wider accumulator and output saturation to
//   the DATA_SIZE signed range; without it the accumulator wraps.
// Ports
//   clock       in   1          single clock, posedge
//   reset       in   1          synchronous, active-high
//   x_in        in   DATA_SIZE  input FIFO head (first-word fall-through)
//   x_rd_en     out  1          input FIFO pop
//   x_empty     in   1          input FIFO empty
//   y_out       out  DATA_SIZE  output sample (0 outside WRITE)
//   y_wr_en     out  1          output FIFO push
//   y_out_full  in   1          output FIFO full
// -----------------------------------------------------------------------------
module fir_interp
  import fir_pkg::*;
#(
  parameter int                              TAPS         = 32,
  parameter int                              INTERP       = 4,
  parameter int                              DATA_SIZE    = 32,
  parameter logic [0:TAPS-1][DATA_SIZE-1:0]  GLOBAL_COEFF = '0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] x_in,
  output logic                 x_rd_en,
  input  logic                 x_empty,
  output logic [DATA_SIZE-1:0] y_out,
  output logic                 y_wr_en,
  input  logic                 y_out_full
);

  localparam int PHASE_TAPS = TAPS / INTERP;
  localparam int ACC_W      = DATA_SIZE + ACC_GUARD;
  localparam int TAP_W      = (PHASE_TAPS > 1) ? $clog2(PHASE_TAPS) : 1;
  localparam int PHASE_W    = (INTERP > 1) ? $clog2(INTERP) : 1;
  localparam int COEFF_W    = (TAPS > 1) ? $clog2(TAPS) : 1;

  localparam logic [TAP_W-1:0]   LAST_TAP   = TAP_W'(PHASE_TAPS - 1);
  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(INTERP - 1);

  fir_interp_state_t           state;
  logic signed [DATA_SIZE-1:0] delay [PHASE_TAPS];  // delay[0] is newest
  logic signed [ACC_W-1:0]     acc;
  logic signed [ACC_W-1:0]     acc_next;
  logic [TAP_W-1:0]            tap_cnt;
  logic [PHASE_W-1:0]          phase_cnt;
  logic [COEFF_W-1:0]          coeff_idx;
  logic [DATA_SIZE-1:0]        y_value;

  // Polyphase decomposition: phase p uses prototype taps p, p+INTERP, ...
  assign coeff_idx = COEFF_W'(int'(tap_cnt) * INTERP + int'(phase_cnt));

  fir_interp_mac #(
    .DATA_SIZE (DATA_SIZE),
    .ACC_W     (ACC_W)
  ) u_mac (
    .sample (delay[tap_cnt]),
    .coeff  ($signed(GLOBAL_COEFF[coeff_idx])),
    .acc    (acc),
    .sum    (acc_next)
  );

`ifdef FIR_INTERP_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'({1'b0, {(DATA_SIZE-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  always_comb begin
    if (acc > SAT_MAX)      y_value = SAT_MAX[DATA_SIZE-1:0];
    else if (acc < SAT_MIN) y_value = SAT_MIN[DATA_SIZE-1:0];
    else                    y_value = acc[DATA_SIZE-1:0];
  end
`else
  assign y_value = acc;
`endif

  // FIFO handshakes are combinational so a pop/push costs no extra cycle.
  // Gating with reset keeps all outputs quiet while reset is held, even if the
  // sequencer was caught in WRITE.
  always_comb begin
    x_rd_en = (state == READ)  && !x_empty    && !reset;
    y_wr_en = (state == WRITE) && !y_out_full && !reset;
    y_out   = ((state == WRITE) && !reset) ? y_value : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the delay-line shift below depends on that.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= READ;
      acc       <= '0;
      tap_cnt   <= '0;
      phase_cnt <= '0;
      // NOTE: the delay line is a handful of flops, not a RAM, so it is
      // cleared on reset; a restarted stream must not see stale history.
      for (int i = 0; i < PHASE_TAPS; i++) delay[i] <= '0;
    end else begin
      unique case (state)
        READ: begin
          if (x_rd_en) begin
            delay[0] <= x_in;
            for (int i = 1; i < PHASE_TAPS; i++) delay[i] <= delay[i-1];
            acc       <= '0;
            tap_cnt   <= '0;
            phase_cnt <= '0;
            state     <= MAC;
          end
        end
        MAC: begin
          acc <= acc_next;
          if (tap_cnt == LAST_TAP) state <= WRITE;
          else                     tap_cnt <= tap_cnt + 1'b1;
        end
        WRITE: begin
          // While the output FIFO is full, acc and phase stay put so y_out holds.
          if (y_wr_en) begin
            if (phase_cnt == LAST_PHASE) begin
              state <= READ;
            end else begin
              phase_cnt <= phase_cnt + 1'b1;
              acc       <= '0;
              tap_cnt   <= '0;
              state     <= MAC;
            end
          end
        end
        default: state <= READ;
      endcase
    end
  end

endmodule
